l2cache_mem_bridge: RTL
=======================

// Module: l2cache_mem_bridge
// PURPOSE
//  Memory-side responder for the L2 cache miss/writeback interface. Accepts L2 line reads
//  (refill) and line writes (dirty writeback), plus single-word strongly-ordered (SUC)
//  accesses, and converts them to AXI4 INCR bursts. Answers with addrOK_r/addrOK_w/dataOK.
//  Sits between the L2 cache and the SoC AXI interconnect.
// PARAMETERS
//  OFFSET_W   2    log2(words per line); LINE_W = 32<<OFFSET_W (128 by default)
//  AXI_ID     0    constant ARID/AWID driven on every burst
// PORTS
//  clk                    in   1       single clock, all logic rising-edge
//  rst                    in   1       asynchronous, active-high reset
//  l2cache_mem_req_r      in   1       read request, level, held until addrOK_r
//  l2cache_mem_req_w      in   1       write request, level, held until addrOK_w
//  l2cache_mem_rdy        in   1       L2 ready to take read data
//  l2cache_mem_suc        in   1       request is single-word strongly ordered (no burst)
//  l2cache_mem_addr_r     in   32      read address
//  l2cache_mem_addr_w     in   32      write address
//  l2cache_mem_wdata      in   LINE_W  write line; SUC uses [31:0]
//  mem_l2cache_addrOK_r   out  1       1-cycle pulse: read request latched
//  mem_l2cache_addrOK_w   out  1       1-cycle pulse: write request + data latched
//  mem_l2cache_dataOK     out  1       1-cycle pulse: rdata valid and consumed
//  mem_l2cache_rdata      out  LINE_W  read line; word0 = lowest address
//  araddr/arlen/arsize/arburst/arid/arvalid out, arready in  AXI AR
//  rdata[31:0]/rlast/rvalid in, rready out                    AXI R
//  awaddr/awlen/awsize/awburst/awid/awvalid out, awready in  AXI AW
//  wdata[31:0]/wstrb[3:0]/wlast/wvalid out, wready in         AXI W
//  bvalid in, bready out                                      AXI B
// BEHAVIOUR
//  Reset: all outputs 0, both FSMs idle, beat counters 0, buffers 0.
//  Two independent FSMs. Read: R_IDLE->R_AR->R_DATA->R_RESP->R_IDLE.
//    Write: W_IDLE->W_AW->W_DATA->W_B->W_IDLE.
//  Write accept: W_IDLE & req_w -> addrOK_w pulse same cycle; latch addr, wdata, suc
//    next edge; enter W_AW. L2 may drop req_w the next cycle.
//  Read accept: R_IDLE & req_r & W_IDLE & !req_w -> addrOK_r pulse; latch addr, suc;
//    enter R_AR. Read never accepted while a write is pending or being accepted
//    (writeback-before-refill ordering, same-line RAW safe). req_r & req_w together:
//    write wins, read accepted earliest the cycle after W_B completes.
//  Line access: addr[OFFSET_W+1:0] forced 0, arlen/awlen = 2^OFFSET_W-1, size 3'b010,
//    burst INCR. SUC: exact addr, len 0; write wstrb 4'hF.
//  R_AR: arvalid=1 until arready; R_DATA: rready=1, each rvalid beat stored into word
//    [cnt], cnt++ (wraps at 2^OFFSET_W); leave on rvalid&rlast. SUC beat -> word0,
//    upper words 0. rlast earlier/later than cnt expects: rlast governs exit.
//  R_RESP: mem_l2cache_rdata stable; dataOK=1 only when rdy=1 -> R_IDLE same edge;
//    else hold in R_RESP. Read latency: >= 3 cycles after addrOK_r plus AXI latency.
//  W_AW: awvalid until awready; W_DATA: wvalid=1, wdata=word[cnt], wlast on final beat;
//    cnt++ on wready; exit after last beat handshake. AW and W not overlapped.
//  W_B: bready=1; bvalid -> W_IDLE (BRESP ignored).
//  valid signals never drop before their ready; payload stable while valid&!ready.
//  Reset mid-burst: FSMs return to idle immediately, AXI valids deassert (bench/system
//    reset also resets interconnect); no partial dataOK.
// STRUCTURE
//  Package l2_mem_pkg: R_*/W_* state encodings (2-bit each), AXI_SIZE_WORD=3'b010,
//    AXI_BURST_INCR=2'b01, LINE_W/WORDS derivation function.
//  Sub-module l2_line_beat_buf: LINE_W register, word-indexed load (rd assembly) and
//    word-indexed read mux (wr disassembly) with beat counter; instanced twice.
// TESTING
//  1 Line read @0x1000_0014, arready after 2 cyc, beats A,B,C,D -> addrOK_r 1 cyc,
//    araddr=0x1000_0010 arlen=3, rdata={D,C,B,A}, dataOK 1 cyc with rdy=1.
//  2 Line write @0x2000_0030 data {4,3,2,1}, wready toggled -> addrOK_w same cyc as req,
//    awlen=3, W beats 1,2,3,4 in order, wlast on 4th, bready until bvalid.
//  3 req_w & req_r same cycle -> addrOK_w first; arvalid not before bvalid handshake.
//  4 SUC read @0x1FE0_01F9 -> araddr=0x1FE0_01F9 arlen=0, rdata=={96'b0,beat}.
//  5 rdy held 0 for 5 cyc in R_RESP -> no dataOK, rdata stable; dataOK on rdy=1.
//  6 rst asserted mid R_DATA (beat 2) -> rready/arvalid 0 next cycle, no dataOK; new read ok.

Source files
------------

// File: rtl/l2_mem_pkg.sv
// Shared constants for the L2 <-> AXI memory bridge: FSM state encodings,
// AXI burst attributes and line-geometry helpers.
package l2_mem_pkg;

  // Read FSM encodings
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  // Write FSM encodings
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_B    = 2'd3;

  // AXI burst attributes: 32-bit beats, incrementing addresses
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         AXI_ID_W       = 4;

  // Line width in bits for a line of 2^offset_w 32-bit words
  function automatic int line_width(input int offset_w);
    return 32 << offset_w;
  endfunction

  // Number of 32-bit words in a line
  function automatic int line_words(input int offset_w);
    return 1 << offset_w;
  endfunction

endpackage

// File: rtl/l2_line_beat_buf.sv
// One cache line held as 32-bit words plus a beat counter. The read path
// assembles AXI beats into the line; the write path loads a whole line and
// reads it back out one word per beat.
module l2_line_beat_buf
  import l2_mem_pkg::*;
#(
  parameter  int OFFSET_W = 2,
  localparam int LINE_W   = line_width(OFFSET_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic [LINE_W-1:0]   load_line,
  input  logic                beat_we,
  input  logic [31:0]         beat_word,
  input  logic                cnt_inc,
  output logic [LINE_W-1:0]   line,
  output logic [31:0]         word,
  output logic [OFFSET_W-1:0] cnt
);

  // Line storage and beat counter; clear/load restart the counter at word 0
  // NOTE: the line storage itself is reset, not only the counter, because the
  // L2 side must observe an all-zero read line straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments everywhere here, so each register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      line <= '0;
      cnt  <= '0;
    end else if (clr) begin
      line <= '0;
      cnt  <= '0;
    end else if (load) begin
      line <= load_line;
      cnt  <= '0;
    end else begin
      if (beat_we) line[32*int'(cnt) +: 32] <= beat_word;
      if (cnt_inc) cnt <= cnt + 1'b1;
    end
  end

  // Word currently addressed by the beat counter
  assign word = line[32*int'(cnt) +: 32];

endmodule

// File: rtl/l2cache_mem_bridge.sv
// Memory-side responder for the L2 cache: turns line refills, dirty
// writebacks and single-word strongly-ordered accesses into AXI4 INCR
// bursts. Independent read and write FSMs; a read is only accepted with the
// write side idle so a writeback always reaches memory before a refill.
module l2cache_mem_bridge
  import l2_mem_pkg::*;
#(
  parameter  int OFFSET_W = 2,
  parameter  int AXI_ID   = 0,
  localparam int LINE_W   = line_width(OFFSET_W)
) (
  input  logic                clk,
  input  logic                rst,
  // L2 side
  input  logic                l2cache_mem_req_r,
  input  logic                l2cache_mem_req_w,
  input  logic                l2cache_mem_rdy,
  input  logic                l2cache_mem_suc,
  input  logic [31:0]         l2cache_mem_addr_r,
  input  logic [31:0]         l2cache_mem_addr_w,
  input  logic [LINE_W-1:0]   l2cache_mem_wdata,
  output logic                mem_l2cache_addrOK_r,
  output logic                mem_l2cache_addrOK_w,
  output logic                mem_l2cache_dataOK,
  output logic [LINE_W-1:0]   mem_l2cache_rdata,
  // AXI AR
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [AXI_ID_W-1:0] arid,
  output logic                arvalid,
  input  logic                arready,
  // AXI R
  input  logic [31:0]         rdata,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI AW
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [AXI_ID_W-1:0] awid,
  output logic                awvalid,
  input  logic                awready,
  // AXI W
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  // AXI B
  input  logic                bvalid,
  output logic                bready
);

  localparam int                  WORDS     = line_words(OFFSET_W);
  localparam logic [31:0]         LINE_MASK = ~((32'd1 << (OFFSET_W + 2)) - 32'd1);
  localparam logic [7:0]          LINE_LEN  = 8'(WORDS - 1);
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state;
  logic                w_suc;
  logic                w_idle;
  logic [31:0]         wr_word;
  logic [OFFSET_W-1:0] wr_cnt;
  logic [LINE_W-1:0]   wr_line_unused;
  logic [31:0]         rd_word_unused;
  logic [OFFSET_W-1:0] rd_cnt_unused;

  assign w_idle = (w_state == W_IDLE);

  // Handshakes toward the L2 are combinational so acceptance lands in the
  // request cycle; the read side yields to any write pending or arriving.
  assign mem_l2cache_addrOK_w = w_idle & l2cache_mem_req_w;
  assign mem_l2cache_addrOK_r = (r_state == R_IDLE) & l2cache_mem_req_r & w_idle & ~l2cache_mem_req_w;
  assign mem_l2cache_dataOK   = (r_state == R_RESP) & l2cache_mem_rdy;

  assign arvalid = (r_state == R_AR);
  assign rready  = (r_state == R_DATA);
  assign awvalid = (w_state == W_AW);
  assign wvalid  = (w_state == W_DATA);
  assign bready  = (w_state == W_B);
  assign arid    = AXI_ID_W'(AXI_ID);
  assign awid    = AXI_ID_W'(AXI_ID);
  assign wdata   = wr_word;
  assign wstrb   = wvalid ? 4'hF : 4'h0;
  assign wlast   = wvalid & (w_suc | (wr_cnt == LAST_BEAT));

  // Read FSM: latch the AR payload on accept, then AR, R beats, L2 response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      araddr  <= '0;
      arlen   <= '0;
      arsize  <= '0;
      arburst <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (mem_l2cache_addrOK_r) begin
          araddr  <= l2cache_mem_suc ? l2cache_mem_addr_r : (l2cache_mem_addr_r & LINE_MASK);
          arlen   <= l2cache_mem_suc ? 8'd0 : LINE_LEN;
          arsize  <= AXI_SIZE_WORD;
          arburst <= AXI_BURST_INCR;
          r_state <= R_AR;
        end
        R_AR:    if (arready) r_state <= R_DATA;
        // rlast, not the beat count, ends the burst
        R_DATA:  if (rvalid && rlast) r_state <= R_RESP;
        R_RESP:  if (l2cache_mem_rdy) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: latch AW payload and SUC flag on accept, then AW, W beats, B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_suc   <= 1'b0;
      awaddr  <= '0;
      awlen   <= '0;
      awsize  <= '0;
      awburst <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (mem_l2cache_addrOK_w) begin
          w_suc   <= l2cache_mem_suc;
          awaddr  <= l2cache_mem_suc ? l2cache_mem_addr_w : (l2cache_mem_addr_w & LINE_MASK);
          awlen   <= l2cache_mem_suc ? 8'd0 : LINE_LEN;
          awsize  <= AXI_SIZE_WORD;
          awburst <= AXI_BURST_INCR;
          w_state <= W_AW;
        end
        W_AW:    if (awready) w_state <= W_DATA;
        W_DATA:  if (wready && wlast) w_state <= W_B;
        W_B:     if (bvalid) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Refill assembly: cleared on accept so a SUC read leaves upper words zero
  l2_line_beat_buf #(.OFFSET_W(OFFSET_W)) u_rd_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (mem_l2cache_addrOK_r),
    .load      (1'b0),
    .load_line ('0),
    .beat_we   (rvalid & rready),
    .beat_word (rdata),
    .cnt_inc   (rvalid & rready),
    .line      (mem_l2cache_rdata),
    .word      (rd_word_unused),
    .cnt       (rd_cnt_unused)
  );

  // Writeback disassembly: whole line captured on accept, one word per beat
  l2_line_beat_buf #(.OFFSET_W(OFFSET_W)) u_wr_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .load      (mem_l2cache_addrOK_w),
    .load_line (l2cache_mem_wdata),
    .beat_we   (1'b0),
    .beat_word (32'd0),
    .cnt_inc   (wvalid & wready),
    .line      (wr_line_unused),
    .word      (wr_word),
    .cnt       (wr_cnt)
  );

endmodule
